// File: rtl/drive_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// drive_arbiter_pkg
// Shared definitions for the drive arbiter:
//   - state_t       : FSM state encoding (also driven out on state_out)
//   - MV_*          : legal moving-state command codes
//   - SRC_*         : request source bit positions (lower index = higher priority)
//   - helper functions for command sanitising, owner selection and muxing
// ---------------------------------------------------------------------------
package drive_arbiter_pkg;

   localparam int CNT_W = 11;

   typedef enum logic [1:0] {
      ST_OFF    = 2'b00,
      ST_IDLE   = 2'b01,
      ST_ACTIVE = 2'b10,
      ST_SWITCH = 2'b11
   } state_t;

   localparam logic [3:0] MV_STOP  = 4'b0000;
   localparam logic [3:0] MV_FWD   = 4'b0001;
   localparam logic [3:0] MV_BACK  = 4'b0010;
   localparam logic [3:0] MV_RIGHT = 4'b0100;
   localparam logic [3:0] MV_LEFT  = 4'b1000;

   localparam int SRC_MANUAL = 0;
   localparam int SRC_SEMI   = 1;
   localparam int SRC_AUTO   = 2;
   localparam int NUM_SRC    = 3;

   // Anything outside the five legal codes is treated as a stop request.
   function automatic logic [3:0] sanitize_cmd(input logic [3:0] c);
      case (c)
         MV_STOP, MV_FWD, MV_BACK, MV_RIGHT, MV_LEFT: return c;
         default:                                     return MV_STOP;
      endcase
   endfunction

   // One-hot grant for the highest-priority (lowest-index) active request.
   function automatic logic [NUM_SRC-1:0] pick_owner(input logic [NUM_SRC-1:0] r);
      if (r[SRC_MANUAL])    return 3'b001;
      else if (r[SRC_SEMI]) return 3'b010;
      else if (r[SRC_AUTO]) return 3'b100;
      else                  return 3'b000;
   endfunction

   // Mask of sources that outrank the one-hot owner g (all bits below it).
   function automatic logic [NUM_SRC-1:0] higher_mask(input logic [NUM_SRC-1:0] g);
      return (g - 3'd1) & ~g;
   endfunction

   // Select a source command by one-hot selector; zero selector gives STOP.
   function automatic logic [3:0] cmd_mux(input logic [NUM_SRC-1:0] sel,
                                          input logic [3:0] c0,
                                          input logic [3:0] c1,
                                          input logic [3:0] c2);
      return ({4{sel[SRC_MANUAL]}} & c0) |
             ({4{sel[SRC_SEMI]}}   & c1) |
             ({4{sel[SRC_AUTO]}}   & c2);
   endfunction

endpackage

// File: rtl/drive_arbiter_ms_counter.sv
// ---------------------------------------------------------------------------
// ms_counter
// 11-bit millisecond tick counter with synchronous clear and a terminal
// match strobe. hit is combinational and fires on the tick that brings the
// count up to limit; the counter wraps to zero on that same edge.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous clear (wins over tick)
//   tick      : count enable (one-clk 1 ms strobe, already gated by caller)
//   limit     : terminal value (1..2047)
//   hit       : this tick completes the count
// ---------------------------------------------------------------------------
module ms_counter
   import drive_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             tick,
   input  logic [CNT_W-1:0] limit,
   output logic             hit
);

   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   count_inc;

   // Extra bit so a limit of 2047 cannot alias through wrap-around.
   assign count_inc = {1'b0, count} + 1'b1;
   assign hit       = tick & ~clear & (count_inc == {1'b0, limit});

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || hit) begin
         count <= '0;
      end else if (tick) begin
         count <= count_inc[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/drive_arbiter.sv
// ---------------------------------------------------------------------------
// drive_arbiter
// Power sequencing and drive-ownership arbiter for three command sources
// (manual > semi-auto > auto). Power comes up after the on button is held for
// BOOT_MS ticks; ownership changes pass through a forced-stop dwell of
// GUARD_MS ticks. All outputs are registered.
//
// Optional feature: define DRIVE_ARB_WATCHDOG_EN to add a watchdog that
// drops an owner whose command stays nonzero and unchanged for 4096 ticks,
// and a wdog flag output held until the next grant.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   tick_ms           : one-clk 1 ms strobe
//   pwr_on_btn        : debounced power-on button level
//   pwr_off_btn       : debounced power-off button level
//   req[2:0]          : drive request per source (0 manual, 1 semi, 2 auto)
//   kill[2:0]         : power-kill strobe per source
//   cmd0, cmd1, cmd2  : moving-state command per source
//   power             : drive power enable
//   grant[2:0]        : one-hot current owner (zero outside ACTIVE)
//   motor_cmd[3:0]    : command forwarded to the motor stage
//   state_out[1:0]    : 00 OFF, 01 IDLE, 10 ACTIVE, 11 SWITCH
//   wdog              : (watchdog build only) owner was timed out
// ---------------------------------------------------------------------------
module drive_arbiter
   import drive_arbiter_pkg::*;
#(
   parameter int BOOT_MS  = 1000,
   parameter int GUARD_MS = 200
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick_ms,
   input  logic         pwr_on_btn,
   input  logic         pwr_off_btn,
   input  logic [2:0]   req,
   input  logic [2:0]   kill,
   input  logic [3:0]   cmd0,
   input  logic [3:0]   cmd1,
   input  logic [3:0]   cmd2,
   output logic         power,
   output logic [2:0]   grant,
   output logic [3:0]   motor_cmd,
   output logic [1:0]   state_out
`ifdef DRIVE_ARB_WATCHDOG_EN
   ,
   output logic         wdog
`endif
);

   localparam logic [CNT_W-1:0] BOOT_LIM  = CNT_W'(BOOT_MS);
   localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_MS);

   state_t           state;
   logic [2:0]       new_grant;
   logic [3:0]       new_cmd;
   logic [3:0]       owner_cmd;
   logic             power_kill;
   logic             preempt;
   logic             cnt_tick;
   logic             cnt_clear;
   logic             cnt_hit;
   logic [CNT_W-1:0] cnt_limit;

   assign state_out = state;

   assign new_grant = pick_owner(req);
   assign new_cmd   = sanitize_cmd(cmd_mux(new_grant, cmd0, cmd1, cmd2));
   assign owner_cmd = cmd_mux(grant, cmd0, cmd1, cmd2);

   // Only the owner's kill counts; grant is zero outside ACTIVE, so in IDLE
   // any kill bit is taken instead. SWITCH has no owner to kill.
   assign power_kill = pwr_off_btn
                     | ((state == ST_IDLE) & (|kill))
                     | (|(kill & grant));

   // Owner released its request, or someone of higher priority asked.
   assign preempt = ~(|(req & grant)) | (|(req & higher_mask(grant)));

   // One counter serves both boot (OFF) and guard (SWITCH) timing; it is held
   // clear in IDLE/ACTIVE so each use starts from zero.
   assign cnt_limit = (state == ST_OFF) ? BOOT_LIM : GUARD_LIM;
   assign cnt_tick  = tick_ms & (((state == ST_OFF) & pwr_on_btn & ~pwr_off_btn)
                               | (state == ST_SWITCH));
   assign cnt_clear = ((state == ST_OFF) & (~pwr_on_btn | pwr_off_btn))
                    | (state == ST_IDLE)
                    | (state == ST_ACTIVE)
                    | ((state == ST_SWITCH) & power_kill);

   ms_counter u_ms_counter (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clear),
      .tick  (cnt_tick),
      .limit (cnt_limit),
      .hit   (cnt_hit)
   );

`ifdef DRIVE_ARB_WATCHDOG_EN
   logic [11:0] wd_cnt;
   logic [3:0]  wd_prev;
   logic        wd_hold;
   logic        wd_hit;

   // Command is considered stuck only while it stays nonzero and identical.
   assign wd_hold = (state == ST_ACTIVE) & (owner_cmd != MV_STOP)
                  & (owner_cmd == wd_prev);
   assign wd_hit  = wd_hold & tick_ms & (wd_cnt == 12'hFFF);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt  <= '0;
         wd_prev <= MV_STOP;
      end else begin
         wd_prev <= owner_cmd;
         if (!wd_hold) begin
            wd_cnt <= '0;
         end else if (tick_ms) begin
            wd_cnt <= wd_cnt + 12'd1;
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_OFF;
         power     <= 1'b0;
         grant     <= '0;
         motor_cmd <= MV_STOP;
`ifdef DRIVE_ARB_WATCHDOG_EN
         wdog      <= 1'b0;
`endif
      end else if (state != ST_OFF && power_kill) begin
         // Power-off beats preemption, guard completion and new grants.
         state     <= ST_OFF;
         power     <= 1'b0;
         grant     <= '0;
         motor_cmd <= MV_STOP;
      end else begin
         case (state)
            ST_OFF: begin
               power     <= 1'b0;
               grant     <= '0;
               motor_cmd <= MV_STOP;
               if (cnt_hit) begin
                  state <= ST_IDLE;
                  power <= 1'b1;
               end
            end

            ST_IDLE: begin
               if (|req) begin
                  state     <= ST_ACTIVE;
                  grant     <= new_grant;
                  motor_cmd <= new_cmd;
`ifdef DRIVE_ARB_WATCHDOG_EN
                  wdog      <= 1'b0;
`endif
               end
            end

            ST_ACTIVE: begin
               if (preempt) begin
                  state     <= ST_SWITCH;
                  grant     <= '0;
                  motor_cmd <= MV_STOP;
`ifdef DRIVE_ARB_WATCHDOG_EN
               end else if (wd_hit) begin
                  state     <= ST_SWITCH;
                  grant     <= '0;
                  motor_cmd <= MV_STOP;
                  wdog      <= 1'b1;
`endif
               end else begin
                  motor_cmd <= sanitize_cmd(owner_cmd);
               end
            end

            ST_SWITCH: begin
               motor_cmd <= MV_STOP;
               if (cnt_hit) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state     <= ST_OFF;
               power     <= 1'b0;
               grant     <= '0;
               motor_cmd <= MV_STOP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_drive_arbiter.sv
// ---------------------------------------------------------------------------
// tb_drive_arbiter
// Directed bench for drive_arbiter (default build). A behavioural model
// tracks power/ownership from the arbitration rules; a negedge process
// compares every output against it each cycle, and directed steps add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_drive_arbiter;

   localparam int BOOT  = 1000;
   localparam int GUARD = 200;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_ms;
   logic       pwr_on_btn;
   logic       pwr_off_btn;
   logic [2:0] req;
   logic [2:0] kill;
   logic [3:0] cmd0, cmd1, cmd2;
   logic       power;
   logic [2:0] grant;
   logic [3:0] motor_cmd;
   logic [1:0] state_out;

   always #5 clk = ~clk;

   drive_arbiter #(.BOOT_MS(BOOT), .GUARD_MS(GUARD)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick_ms     (tick_ms),
      .pwr_on_btn  (pwr_on_btn),
      .pwr_off_btn (pwr_off_btn),
      .req         (req),
      .kill        (kill),
      .cmd0        (cmd0),
      .cmd1        (cmd1),
      .cmd2        (cmd2),
      .power       (power),
      .grant       (grant),
      .motor_cmd   (motor_cmd),
      .state_out   (state_out)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 off, 1 idle, 2 driving, 3 forced-stop dwell
   int         m_mode, m_cnt, m_owner;
   logic       m_power;
   logic [2:0] m_grant;
   logic [3:0] m_motor;
   bit         m_die, m_pre;

   function automatic logic [3:0] src_cmd(input int s);
      case (s)
         0:       return cmd0;
         1:       return cmd1;
         default: return cmd2;
      endcase
   endfunction

   // Legal codes are zero or a single set bit.
   function automatic logic [3:0] clean(input logic [3:0] c);
      return ($countones(c) <= 1) ? c : 4'b0000;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_owner = 0;
         m_power = 1'b0; m_grant = 3'b000; m_motor = 4'b0000;
      end else begin
         m_die = (m_mode == 1 && kill != 3'b000) || (m_mode == 2 && kill[m_owner]);
         if (m_mode != 0 && (pwr_off_btn || m_die)) begin
            m_mode = 0; m_cnt = 0;
            m_power = 1'b0; m_grant = 3'b000; m_motor = 4'b0000;
         end else begin
            case (m_mode)
               0: begin
                  if (!pwr_on_btn || pwr_off_btn) m_cnt = 0;
                  else if (tick_ms) begin
                     m_cnt++;
                     if (m_cnt == BOOT) begin
                        m_mode = 1; m_power = 1'b1; m_cnt = 0;
                     end
                  end
               end
               1: begin
                  if (req != 3'b000) begin
                     for (int i = 2; i >= 0; i--) if (req[i]) m_owner = i;
                     m_grant = 3'(1 << m_owner);
                     m_motor = clean(src_cmd(m_owner));
                     m_mode  = 2;
                  end
               end
               2: begin
                  m_pre = !req[m_owner];
                  for (int i = 0; i < m_owner; i++) if (req[i]) m_pre = 1'b1;
                  if (m_pre) begin
                     m_mode = 3; m_grant = 3'b000; m_motor = 4'b0000;
                  end else begin
                     m_motor = clean(src_cmd(m_owner));
                  end
               end
               default: begin
                  if (tick_ms) begin
                     m_cnt++;
                     if (m_cnt == GUARD) begin
                        m_mode = 1; m_cnt = 0;
                     end
                  end
               end
            endcase
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         logic [1:0] m_state;
         m_state = 2'(m_mode);
         check("cycle_outputs", {22'd0, power, grant, motor_cmd, state_out},
               {22'd0, m_power, m_grant, m_motor, m_state});
      end
   end

   // ---------------- stimulus helpers ----------------
   // All helpers start and end just after a falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic pulse(input int n, input int gap);
      repeat (n) begin
         tick_ms = 1'b1;
         @(negedge clk);
         tick_ms = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic boot();
      pwr_on_btn = 1'b1;
      pulse(BOOT, 0);
      pwr_on_btn = 1'b0;
   endtask

   task automatic guard_wait();
      pulse(GUARD - 1, 1);
      pulse(1, 0);
   endtask

   initial begin
      rst = 1'b1; tick_ms = 1'b0; pwr_on_btn = 1'b0; pwr_off_btn = 1'b0;
      req = 3'b000; kill = 3'b000; cmd0 = 4'b0000; cmd1 = 4'b0000; cmd2 = 4'b0000;
      repeat (3) step();
      check("reset_power", power, 0);
      check("reset_state", state_out, 0);
      check("reset_grant", grant, 0);
      check("reset_motor", motor_cmd, 0);
      rst = 1'b0;
      cmp_en = 1'b1;

      // Release at tick 999, then a full 1000 is needed from zero.
      pwr_on_btn = 1'b1;
      pulse(BOOT - 1, 0);
      pwr_on_btn = 1'b0;
      step();
      check("abort_999_state", state_out, 0);
      pwr_on_btn = 1'b1;
      pulse(BOOT - 1, 0);
      check("reboot_999_state", state_out, 0);
      pulse(1, 0);
      check("boot_state", state_out, 1);
      check("boot_power", power, 1);
      pwr_on_btn = 1'b0;

      // Semi-auto wins over auto; manual then preempts through the guard.
      cmd0 = 4'b0100; cmd1 = 4'b0001; cmd2 = 4'b1000;
      req = 3'b110;
      step();
      check("semi_grant", grant, 3'b010);
      check("semi_motor", motor_cmd, 4'b0001);
      check("semi_state", state_out, 2);
      cmd1 = 4'b0010;
      step();
      check("semi_motor_follow", motor_cmd, 4'b0010);
      req = 3'b111;
      step();
      check("preempt_grant", grant, 3'b000);
      check("preempt_motor", motor_cmd, 4'b0000);
      check("preempt_state", state_out, 3);
      pulse(GUARD - 1, 1);
      check("guard_199_state", state_out, 3);
      check("guard_199_grant", grant, 3'b000);
      pulse(1, 0);
      check("guard_done_state", state_out, 1);
      step();
      check("manual_grant", grant, 3'b001);
      check("manual_motor", motor_cmd, 4'b0100);

      // Auto owner: illegal command is stopped, legal one passes.
      req = 3'b100;
      step();
      check("drop_state", state_out, 3);
      guard_wait();
      step();
      check("auto_grant", grant, 3'b100);
      check("auto_motor", motor_cmd, 4'b1000);
      cmd2 = 4'b0011;
      step();
      check("auto_illegal_motor", motor_cmd, 4'b0000);
      cmd2 = 4'b1000;
      step();
      check("auto_legal_motor", motor_cmd, 4'b1000);
      kill = 3'b001;
      step();
      kill = 3'b000;
      check("nonowner_kill_grant", grant, 3'b100);
      check("nonowner_kill_power", power, 1);

      // Manual owner: foreign kill ignored, own kill powers down.
      req = 3'b101;
      step();
      check("to_manual_state", state_out, 3);
      guard_wait();
      step();
      check("manual2_grant", grant, 3'b001);
      kill = 3'b100;
      step();
      kill = 3'b000;
      check("auto_kill_ignored", grant, 3'b001);
      kill = 3'b001;
      step();
      kill = 3'b000;
      check("owner_kill_power", power, 0);
      check("owner_kill_state", state_out, 0);
      check("owner_kill_grant", grant, 3'b000);

      // Both buttons held: never boots; afterwards a full count is needed.
      req = 3'b000;
      pwr_on_btn = 1'b1; pwr_off_btn = 1'b1;
      pulse(1500, 0);
      check("both_btn_state", state_out, 0);
      pwr_off_btn = 1'b0;
      pulse(BOOT - 1, 0);
      check("after_both_999", state_out, 0);
      pulse(1, 0);
      check("after_both_boot", state_out, 1);
      pwr_on_btn = 1'b0;

      // Any kill in IDLE powers down.
      kill = 3'b010;
      step();
      kill = 3'b000;
      check("idle_kill_state", state_out, 0);
      check("idle_kill_power", power, 0);

      // Off button beats a same-cycle preemption.
      boot();
      req = 3'b010;
      step();
      check("semi2_grant", grant, 3'b010);
      req = 3'b011; pwr_off_btn = 1'b1;
      step();
      pwr_off_btn = 1'b0;
      check("off_vs_preempt_state", state_out, 0);
      check("off_vs_preempt_power", power, 0);

      // Asynchronous reset in the middle of SWITCH.
      req = 3'b000;
      boot();
      req = 3'b100;
      step();
      req = 3'b000;
      step();
      check("mid_switch_state", state_out, 3);
      pulse(50, 0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_state", state_out, 0);
      check("async_rst_power", power, 0);
      check("async_rst_grant", grant, 0);
      check("async_rst_motor", motor_cmd, 0);
      pwr_on_btn = 1'b1; tick_ms = 1'b1;
      repeat (3) step();
      tick_ms = 1'b0;
      rst = 1'b0;
      pulse(BOOT - 1, 0);
      check("post_rst_999", state_out, 0);
      pulse(1, 0);
      check("post_rst_boot", state_out, 1);
      pwr_on_btn = 1'b0;
      step();

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
